accumulator_ctrl: RTL and testbench

//   Consumer side of the ula interface. Drives ula operands (A_in, B_in, operation) from an accumulator register.

---
 rtl/accumulator_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_accumulator_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// accumulator_ctrl
//
// Purpose:
//   Consumer side of the ula interface. Holds an accumulator register, feeds
//   its registered copy and a command operand to the combinational ula,
//   captures the ula result back into the accumulator and reports status
//   flags. Commands arrive on a valid/ready port, one in flight at a time,
//   with a fixed three-cycle turnaround (IDLE -> EXEC -> DONE -> IDLE).
//
// Ports:
//   clock_in       in   1      system clock, rising edge
//   reset_in       in   1      synchronous, active-high reset
//   cmd_valid_in   in   1      command present
//   cmd_ready_out  out  1      high only in IDLE; accept on valid & ready
//   cmd_op_in      in   2      00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   operand_in     in   WIDTH  command operand
//   A_out          out  WIDTH  ula A_in (registered accumulator copy)
//   B_out          out  WIDTH  ula B_in (registered operand)
//   operation_out  out  1      ula operation: 0 = A+B, 1 = A-B
//   alu_in         in   WIDTH  ula alu_out
//   acc_out        out  WIDTH  accumulator value
//   done_out       out  1      one-cycle pulse when a command completes
//   zero_out       out  1      accumulator == 0 after last write-back
//   neg_out        out  1      accumulator MSB after last write-back
//   ovf_out        out  1      signed overflow of last ADD/SUB
//
// Configuration:
//   ACC_OVF_FLAG_EN  defined   -> ovf_out reports signed overflow.
//                    undefined -> ovf_out is tied low, no overflow logic.
// ---------------------------------------------------------------------------
module accumulator_ctrl #(
    parameter int WIDTH = 11
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [1:0]       cmd_op_in,
    input  logic [WIDTH-1:0] operand_in,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             operation_out,
    input  logic [WIDTH-1:0] alu_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             done_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic             ovf_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   wb_value;

    // Value written into the accumulator at the end of EXEC.
    always_comb begin
        wb_value = '0;
        case (op_q)
            OP_LOAD:  wb_value = b_q;
            OP_ADD:   wb_value = alu_in;
            OP_SUB:   wb_value = alu_in;
            OP_CLEAR: wb_value = '0;
            default:  wb_value = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid_in && ready_q) begin
                    op_d    = cmd_op_in;
                    a_d     = acc_q;
                    b_d     = operand_in;
                    sub_d   = (cmd_op_in == OP_SUB);
                    state_d = ST_EXEC;
                    ready_d = 1'b0;
                end
            end
            ST_EXEC: begin
                // Ula operands have been stable for a full cycle; commit.
                acc_d   = wb_value;
                zero_d  = (wb_value == '0);
                neg_d   = wb_value[WIDTH-1];
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // ready rises together with the return to IDLE so the
                // registered ready always matches the state.
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

`ifdef ACC_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic a_msb, b_msb, r_msb;

    assign a_msb = a_q[WIDTH-1];
    assign b_msb = b_q[WIDTH-1];
    assign r_msb = alu_in[WIDTH-1];

    // Signed overflow: result sign differs from A while the operand signs
    // make overflow possible (equal for ADD, opposite for SUB).
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_ADD:  ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
                OP_SUB:  ovf_d = (a_msb != b_msb) && (r_msb != a_msb);
                default: ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_out = ovf_q;
`else
    assign ovf_out = 1'b0;
`endif

    assign cmd_ready_out = ready_q;
    assign A_out         = a_q;
    assign B_out         = b_q;
    assign operation_out = sub_q;
    assign acc_out       = acc_q;
    assign done_out      = done_q;
    assign zero_out      = zero_q;
    assign neg_out       = neg_q;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accumulator_ctrl
//
// Bench for accumulator_ctrl. A stand-in ula closes the loop combinationally.
// A behavioural model tracks, per command, the cycle count since acceptance
// and the resulting accumulator/flags using plain signed arithmetic; a
// negedge process compares every DUT output against it each cycle. Directed
// sequences add literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_accumulator_ctrl;

    localparam int W = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          ready;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operand = '0;
    logic [W-1:0]  a_o, b_o, alu, acc;
    logic          sub_o, done, zero, neg, ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational ula.
    assign alu = sub_o ? (a_o - b_o) : (a_o + b_o);

    accumulator_ctrl #(.WIDTH(W)) dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .cmd_valid_in  (valid),
        .cmd_ready_out (ready),
        .cmd_op_in     (op),
        .operand_in    (operand),
        .A_out         (a_o),
        .B_out         (b_o),
        .operation_out (sub_o),
        .alu_in        (alu),
        .acc_out       (acc),
        .done_out      (done),
        .zero_out      (zero),
        .neg_out       (neg),
        .ovf_out       (ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           age = 0;          // cycles since acceptance, 0 = idle
    int           cyc = 0;
    logic [1:0]   m_op = 2'b00;
    logic [W-1:0] m_a = '0, m_b = '0, m_acc = '0;
    bit           m_sub = 0, m_zero = 0, m_neg = 0, m_ovf = 0;
    int           accept_log[$];
    int           done_cnt = 0;
    bit           chk_en = 0;

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    always @(posedge clk) begin
        cyc++;
        chk_en = 1;
        if (rst) begin
            age = 0; m_acc = '0; m_a = '0; m_b = '0; m_sub = 0;
            m_zero = 0; m_neg = 0; m_ovf = 0;
        end else if (age == 0) begin
            if (valid) begin
                m_op = op; m_a = m_acc; m_b = operand; m_sub = (op == 2'b10);
                age = 1;
                accept_log.push_back(cyc);
                $display("accept cyc=%0d op=%0d operand=0x%0h acc=0x%0h", cyc, op, operand, m_acc);
            end
        end else if (age == 1) begin
            int r;
            case (m_op)
                2'b00: begin m_acc = m_b; m_ovf = 0; end
                2'b11: begin m_acc = '0;  m_ovf = 0; end
                2'b01: begin
                    r = sval(m_a) + sval(m_b);
                    m_acc = W'(r);
                    m_ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
                end
                default: begin
                    r = sval(m_a) - sval(m_b);
                    m_acc = W'(r);
                    m_ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
                end
            endcase
            m_zero = (m_acc == 0);
            m_neg  = (sval(m_acc) < 0);
            age = 2;
        end else begin
            age = 0;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_ovf;
`ifdef ACC_OVF_FLAG_EN
            exp_ovf = m_ovf;
`else
            exp_ovf = 0;
`endif
            chk("ready", int'(ready), int'(age == 0));
            chk("done",  int'(done),  int'(age == 2));
            chk("acc",   int'(acc),   int'(m_acc));
            chk("zero",  int'(zero),  int'(m_zero));
            chk("neg",   int'(neg),   int'(m_neg));
            chk("ovf",   int'(ovf),   int'(exp_ovf));
            chk("A_out", int'(a_o),   int'(m_a));
            chk("B_out", int'(b_o),   int'(m_b));
            chk("oper",  int'(sub_o), int'(m_sub));
            if (done === 1'b1) done_cnt++;
        end
    end

    // ---------------- directed helpers ----------------
    logic exec_sub;

    // Called right after a negedge. Returns at the negedge where done is seen.
    task automatic run_cmd(input logic [1:0] c_op, input logic [W-1:0] v);
        int n;
        op = c_op; operand = v; valid = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        @(negedge clk);
        exec_sub = sub_o;
        valid = 1'b0;
        op = 2'($urandom); operand = W'($urandom);  // ignored while idle
        n = 1;
        while (done !== 1'b1 && n < 6) begin @(negedge clk); n++; end
        chk("done_latency", n, 2);
        $display("cmd op=%0d operand=0x%0h -> acc=0x%0h z=%0b n=%0b v=%0b", c_op, v, acc, zero, neg, ovf);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return W'(11'h3FF);
            2: return W'(11'h400);
            3: return W'(11'h7FF);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int exp_ovf_lit;
        int base, d0;
        exp_ovf_lit = 0;
`ifdef ACC_OVF_FLAG_EN
        exp_ovf_lit = 1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_acc",   int'(acc),   0);
        chk("reset_ready", int'(ready), 1);
        chk("reset_done",  int'(done),  0);

        run_cmd(2'b00, 11'h3FF);
        chk("load_acc", int'(acc), 11'h3FF);
        chk("load_zero", int'(zero), 0);
        chk("load_neg", int'(neg), 0);
        chk("load_ovf", int'(ovf), 0);

        run_cmd(2'b01, 11'h001);
        chk("add_oper", int'(exec_sub), 0);
        chk("add_acc", int'(acc), 11'h400);
        chk("add_neg", int'(neg), 1);
        chk("add_ovf", int'(ovf), exp_ovf_lit);

        run_cmd(2'b00, 11'h003);
        run_cmd(2'b10, 11'h002);
        chk("sub1_oper", int'(exec_sub), 1);
        chk("sub1_acc", int'(acc), 11'h001);
        run_cmd(2'b10, 11'h002);
        chk("sub2_acc", int'(acc), 11'h7FF);
        chk("sub2_neg", int'(neg), 1);
        chk("sub2_ovf", int'(ovf), 0);

        run_cmd(2'b11, 11'h123);
        chk("clr_acc", int'(acc), 0);
        chk("clr_zero", int'(zero), 1);
        chk("clr_neg", int'(neg), 0);
        chk("clr_ovf", int'(ovf), 0);

        // Back-to-back with valid held high.
        @(negedge clk);
        base = accept_log.size();
        d0 = done_cnt;
        op = 2'b00; operand = 11'h010; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            op = 2'($urandom_range(1, 2)); operand = rnd_operand();
        end
        valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_accepts", accept_log.size() - base, 3);
        if (accept_log.size() - base == 3) begin
            chk("b2b_gap1", accept_log[base+1] - accept_log[base], 3);
            chk("b2b_gap2", accept_log[base+2] - accept_log[base+1], 3);
        end
        chk("b2b_dones", done_cnt - d0, 3);

        // Reset during EXEC aborts the command.
        run_cmd(2'b00, 11'h010);
        @(negedge clk);
        op = 2'b01; operand = 11'h005; valid = 1'b1;
        begin
            int n = 0;
            while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        valid = 1'b0;
        chk("abort_in_exec", int'(done), 0);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_acc", int'(acc), 0);
        chk("abort_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cmd(2'($urandom), rnd_operand());
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
